// File: rtl/mul_stage_ctrl.sv
// rtl/mul_stage_ctrl.sv - multi-cycle issue/capture wrapper around the EX-stage M-extension multiplier
// Optional feature macro: MUL_STAGE_ZERO_BYPASS_EN (zero-operand ops skip CALC and complete in one clock)

module mul_stage_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int RD_W       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_op_a,
  input  logic [31:0]     in_op_b,
  input  logic [3:0]      in_alu_op,
  input  logic [RD_W-1:0] in_rd,
  output logic [31:0]     mul_op_a,
  output logic [31:0]     mul_op_b,
  output logic [3:0]      mul_alu_op,
  input  logic [31:0]     mul_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

`ifdef MUL_STAGE_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [31:0]       res_q, res_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              accept;
  logic              zero_operand;

  // Ready when idle, or when the held result is being consumed this cycle; flush blocks any accept.
  assign in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  assign zero_operand = (in_op_a == 32'd0) | (in_op_b == 32'd0);

  assign mul_op_a   = op_a_q;
  assign mul_op_b   = op_b_q;
  assign mul_alu_op = alu_op_q;
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_rd     = out_rd_q;
  assign busy       = (state_q == S_CALC) | (state_q == S_DONE);

  // Next-state logic: flush dominates, then per-state progress, then a new accept overrides the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    res_d    = res_q;
    out_rd_d = out_rd_q;

    if (flush) begin
      // Operands and the last captured result are intentionally left intact.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_CALC: begin
          if (cnt_q == '0) begin
            // Operand registers have been stable since accept, so the multiplier output has settled.
            res_d    = mul_result;
            out_rd_d = rd_q;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // accept can only be true in IDLE or in DONE while the result is consumed.
      if (accept) begin
        op_a_d   = in_op_a;
        op_b_d   = in_op_b;
        alu_op_d = in_alu_op;
        rd_d     = in_rd;
        cnt_d    = CNT_LOAD;
        state_d  = S_CALC;
        if (ZERO_BYPASS && zero_operand) begin
          // Product of a zero operand is zero for every multiply flavour.
          res_d    = 32'd0;
          out_rd_d = in_rd;
          state_d  = S_DONE;
        end
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      out_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      out_rd_q <= out_rd_d;
    end
  end

endmodule

// File: tb/tb_mul_stage_ctrl.sv
// tb/tb_mul_stage_ctrl.sv - directed self-checking bench for mul_stage_ctrl

module tb_mul_stage_ctrl;

  localparam logic [3:0] ALU_MUL    = 4'd10;
  localparam logic [3:0] ALU_MULH   = 4'd11;
  localparam logic [3:0] ALU_MULHSU = 4'd12;
  localparam logic [3:0] ALU_MULHU  = 4'd13;

`ifdef MUL_STAGE_ZERO_BYPASS_EN
  localparam int ZB_LAT = 1;
`else
  localparam int ZB_LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic [31:0] mul_op_a;
  logic [31:0] mul_op_b;
  logic [3:0]  mul_alu_op;
  logic [31:0] mul_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int total;
  int bad;

  mul_stage_ctrl #(.MUL_CYCLES(2), .RD_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op_a    (in_op_a),
    .in_op_b    (in_op_b),
    .in_alu_op  (in_alu_op),
    .in_rd      (in_rd),
    .mul_op_a   (mul_op_a),
    .mul_op_b   (mul_op_b),
    .mul_alu_op (mul_alu_op),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational multiplier; unknown op codes yield zero.
  logic [63:0] ext_a_s, ext_b_s, ext_b_u;
  always_comb begin
    ext_a_s = {{32{mul_op_a[31]}}, mul_op_a};
    ext_b_s = {{32{mul_op_b[31]}}, mul_op_b};
    ext_b_u = {32'd0, mul_op_b};
    case (mul_alu_op)
      ALU_MUL:    mul_result = 32'(ext_a_s * ext_b_s);
      ALU_MULH:   mul_result = 32'((ext_a_s * ext_b_s) >> 32);
      ALU_MULHSU: mul_result = 32'((ext_a_s * ext_b_u) >> 32);
      ALU_MULHU:  mul_result = 32'(({32'd0, mul_op_a} * ext_b_u) >> 32);
      default:    mul_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and let one edge accept it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [4:0] rd);
    in_op_a   = a;
    in_op_b   = b;
    in_alu_op = op;
    in_rd     = rd;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Clocks until out_valid is seen, bounded at 20.
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
      n++;
    end
  endtask

  int  lat;
  bit  seen;

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op_a   = '0;
    in_op_b   = '0;
    in_alu_op = '0;
    in_rd     = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_mul_op_a", mul_op_a, 0);
    check("rst_mul_alu_op", mul_alu_op, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Basic MUL, latency 2
    issue(32'd7, 32'd6, ALU_MUL, 5'd5);
    check("mul_busy", busy, 1);
    check("mul_op_a_reg", mul_op_a, 7);
    check("mul_op_b_reg", mul_op_b, 6);
    wait_valid(lat);
    check("mul_latency", lat, 2);
    check("mul_result", out_result, 32'h2A);
    check("mul_rd", out_rd, 5);
    check("mul_ready_in_done", in_ready, 1);
    tick();
    check("mul_idle_valid", out_valid, 0);
    check("mul_idle_busy", busy, 0);
    check("mul_idle_ready", in_ready, 1);

    // MULH held with out_ready low
    out_ready = 1'b0;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, ALU_MULH, 5'd9);
    wait_valid(lat);
    check("mulh_latency", lat, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mulh_hold_valid", out_valid, 1);
      check("mulh_hold_result", out_result, 32'h0);
      check("mulh_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("mulh_release", out_valid, 0);

    // MULHU held
    out_ready = 1'b0;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, ALU_MULHU, 5'd10);
    wait_valid(lat);
    for (int i = 0; i < 4; i++) tick();
    check("mulhu_hold_valid", out_valid, 1);
    check("mulhu_result", out_result, 32'hFFFFFFFE);
    check("mulhu_rd", out_rd, 10);
    check("mulhu_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();

    // MULHSU: -2 * 0x80000000 unsigned -> high word 0xFFFFFFFF
    issue(32'hFFFFFFFE, 32'h80000000, ALU_MULHSU, 5'd3);
    wait_valid(lat);
    check("mulhsu_result", out_result, 32'hFFFFFFFF);
    tick();

    // Back-to-back: second op accepted while first result is consumed
    issue(32'd3, 32'd5, ALU_MUL, 5'd1);
    wait_valid(lat);
    in_op_a   = 32'h10;
    in_op_b   = 32'h10;
    in_alu_op = ALU_MUL;
    in_rd     = 5'd2;
    in_valid  = 1'b1;
    #1;
    check("b2b_ready", in_ready, 1);
    check("b2b_first_result", out_result, 15);
    check("b2b_first_rd", out_rd, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_no_dup", out_valid, 0);
    check("b2b_busy", busy, 1);
    wait_valid(lat);
    check("b2b_latency", lat, 2);
    check("b2b_second_result", out_result, 32'h100);
    check("b2b_second_rd", out_rd, 2);
    tick();
    check("b2b_drain", out_valid, 0);

    // Flush in CALC
    issue(32'd9, 32'd9, ALU_MUL, 5'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("flush_never_valid", seen, 0);
    check("flush_keeps_op_a", mul_op_a, 9);
    check("flush_keeps_result", out_result, 32'h100);

    // Flush coinciding with in_valid
    in_op_a   = 32'd11;
    in_op_b   = 32'd2;
    in_alu_op = ALU_MUL;
    in_rd     = 5'd7;
    in_valid  = 1'b1;
    flush     = 1'b1;
    #1;
    check("flush_blocks_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_no_accept_busy", busy, 0);
    check("flush_no_accept_op_a", mul_op_a, 9);

    // Unknown op code: accepted, zero result, normal latency
    issue(32'd5, 32'd5, 4'hF, 5'd6);
    wait_valid(lat);
    check("badop_latency", lat, 2);
    check("badop_result", out_result, 0);
    check("badop_rd", out_rd, 6);
    tick();

    // Zero operand: one clock with bypass, two without
    issue(32'd0, 32'h1234, ALU_MULHSU, 5'd8);
    check("zero_op_b_loaded", mul_op_b, 32'h1234);
    wait_valid(lat);
    check("zero_latency", lat, ZB_LAT - 1 + 1 - (ZB_LAT == 1 ? 1 : 0) + (ZB_LAT == 1 ? 0 : 0));
    check("zero_result", out_result, 0);
    check("zero_rd", out_rd, 8);
    tick();

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    issue(32'd2, 32'd3, ALU_MUL, 5'd12);
    wait_valid(lat);
    check("prerst_result", out_result, 6);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_result", out_result, 0);
    check("arst_rd", out_rd, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_ready_after", in_ready, 1);
    check("arst_busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

endmodule
